// File: rtl/serial_master_port_pkg.sv
// Shared types and defaults for the serial bus master port.
package serial_master_port_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 255;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WREADY,
        S_ADDR,
        S_WGAP,
        S_WDATA,
        S_RWAIT,
        S_RDATA,
        S_SPLIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/serial_shift_tx.sv
// Loadable LSB-first transmit shift register with remaining-bit counter.
module serial_shift_tx #(
    parameter int W  = 12,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_len,
    input  logic          shift,
    output logic          bit_out,
    output logic          empty
);

    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= load_len;
        end else if (shift && cnt != '0) begin
            sreg <= {1'b0, sreg[W-1:1]};
            cnt  <= cnt - CW'(1);
        end
    end

    assign bit_out = sreg[0];
    assign empty   = (cnt == '0);

endmodule

// File: rtl/serial_master_port.sv
// Serial bus initiator: takes one parallel request, wins the bus,
// shifts address/write data out and collects (possibly split) read data.
module serial_master_port
    import serial_master_port_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dreq,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  dbusy,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam int KW = $clog2(DATA_WIDTH);

    state_t                state;
    logic                  mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic [KW-1:0]         k;
    logic [7:0]            tcnt;
    logic                  stall;
    logic                  abort;

    logic                  sh_load;
    logic                  sh_shift;
    logic                  sh_bit;
    logic                  sh_empty;
    logic [SW-1:0]         sh_data;
    logic [CW-1:0]         sh_len;

    // A wait state that made no progress this cycle.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_REQ:           stall = !mbgrant;
            S_WREADY:        stall = !sready;
            S_RWAIT:         stall = !(svalid || ssplit);
            S_SPLIT, S_RDATA: stall = !svalid;
            default:         stall = 1'b0;
        endcase
    end

    assign abort = stall && (tcnt == 8'(TIMEOUT - 1));

    // Bit 0 goes straight to mwdata on load; the shifter supplies the rest.
    always_comb begin
        sh_load  = (state == S_WREADY && sready) || state == S_WGAP;
        sh_shift = (state == S_ADDR || state == S_WDATA) && !sh_empty;
        sh_data  = (state == S_WGAP) ? SW'(wdata >> 1) : SW'(addr >> 1);
        sh_len   = (state == S_WGAP) ? CW'(DATA_WIDTH - 1)
                                     : CW'(ADDR_WIDTH - 1);
    end

    always_comb begin
        rdata_nxt    = rdata;
        rdata_nxt[k] = mrdata;
    end

    serial_shift_tx #(
        .W  (SW),
        .CW (CW)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_data),
        .load_len  (sh_len),
        .shift     (sh_shift),
        .bit_out   (sh_bit),
        .empty     (sh_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mode   <= MODE_READ;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            k      <= '0;
            tcnt   <= '0;
            drdata <= '0;
            ddone  <= 1'b0;
            derr   <= 1'b0;
            mbreq  <= 1'b0;
            mwdata <= 1'b0;
            mmode  <= MODE_READ;
            mvalid <= 1'b0;
        end else if (abort) begin
            state  <= S_DONE;
            ddone  <= 1'b1;
            derr   <= 1'b1;
            mbreq  <= 1'b0;
            mvalid <= 1'b0;
        end else begin
            if (stall) tcnt <= tcnt + 8'd1;
            unique case (state)
                S_IDLE: if (dreq) begin
                    mode  <= dmode;
                    addr  <= daddr;
                    wdata <= dwdata;
                    k     <= '0;
                    tcnt  <= '0;
                    mbreq <= 1'b1;
                    state <= S_REQ;
                end
                S_REQ: if (mbgrant) begin
                    tcnt  <= '0;
                    state <= S_WREADY;
                end
                S_WREADY: if (sready) begin
                    mvalid <= 1'b1;
                    mwdata <= addr[0];
                    mmode  <= mode;
                    state  <= S_ADDR;
                end
                S_ADDR: if (sh_empty) begin
                    mvalid <= 1'b0;
                    mwdata <= 1'b0;
                    tcnt   <= '0;
                    state  <= (mode == MODE_WRITE) ? S_WGAP : S_RWAIT;
                end else begin
                    mwdata <= sh_bit;
                end
                S_WGAP: begin
                    mvalid <= 1'b1;
                    mwdata <= wdata[0];
                    state  <= S_WDATA;
                end
                S_WDATA: if (sh_empty) begin
                    mvalid <= 1'b0;
                    mwdata <= 1'b0;
                    ddone  <= 1'b1;
                    state  <= S_DONE;
                end else begin
                    mwdata <= sh_bit;
                end
                S_RWAIT: if (svalid) begin
                    rdata <= rdata_nxt;
                    k     <= KW'(1);
                    tcnt  <= '0;
                    state <= S_RDATA;
                end else if (ssplit) begin
                    mbreq <= 1'b0;
                    tcnt  <= '0;
                    state <= S_SPLIT;
                end
                S_SPLIT: if (svalid) begin
                    rdata <= rdata_nxt;
                    k     <= KW'(1);
                    tcnt  <= '0;
                    state <= S_RDATA;
                end
                S_RDATA: if (svalid) begin
                    rdata <= rdata_nxt;
                    tcnt  <= '0;
                    if (k == KW'(DATA_WIDTH - 1)) begin
                        drdata <= rdata_nxt;
                        ddone  <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_DONE: begin
                    ddone  <= 1'b0;
                    derr   <= 1'b0;
                    mbreq  <= 1'b0;
                    mmode  <= MODE_READ;
                    mwdata <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbusy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_master_port.sv
// Directed bench for serial_master_port acting as arbiter and slave.
module tb_serial_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b0;
    logic        dmode = 1'b0;
    logic [11:0] daddr = '0;
    logic [7:0]  dwdata = '0;
    logic [7:0]  drdata;
    logic        ddone, derr, dbusy, mbreq, mwdata, mmode, mvalid;
    logic        mbgrant = 1'b0;
    logic        mrdata = 1'b0;
    logic        svalid = 1'b0;
    logic        sready = 1'b1;
    logic        ssplit = 1'b0;

    int vecs = 0;
    int errs = 0;

    logic [7:0]  mem [0:4095];
    logic [11:0] oa;
    logic [7:0]  od, dr;
    int          nv, ngap, fv, ncyc, sdrop;
    bit          done;
    logic        er, mm;

    always #5 clk = ~clk;

    serial_master_port dut (
        .clk     (clk),
        .rst     (rst),
        .dreq    (dreq),
        .dmode   (dmode),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .drdata  (drdata),
        .ddone   (ddone),
        .derr    (derr),
        .dbusy   (dbusy),
        .mbreq   (mbreq),
        .mbgrant (mbgrant),
        .mwdata  (mwdata),
        .mmode   (mmode),
        .mvalid  (mvalid),
        .mrdata  (mrdata),
        .svalid  (svalid),
        .sready  (sready),
        .ssplit  (ssplit)
    );

    // Arbiter + slave agent for one transaction; returns what it saw.
    task automatic drive_bus(
        input  int          gdly,
        input  logic [7:0]  rv,
        input  bit          alt,
        input  bit          split,
        input  int          start,
        input  bit          hold,
        output logic [11:0] a_o,
        output logic [7:0]  d_o,
        output int          nv_o,
        output int          gap_o,
        output int          fv_o,
        output int          cyc_o,
        output bit          done_o,
        output logic [7:0]  dr_o,
        output logic        er_o,
        output int          sdrop_o,
        output logic        mm_o
    );
        int gcnt, p, b;
        a_o = '0; d_o = '0; nv_o = 0; gap_o = 0; fv_o = 0; cyc_o = 0;
        done_o = 0; dr_o = '0; er_o = 1'b0; sdrop_o = 0; mm_o = 1'b0;
        gcnt = 0; p = 0; b = 0;
        for (int c = 1; c <= 600 && !done_o; c++) begin
            @(negedge clk);
            if (!hold) dreq = 1'b0;
            if (ddone) begin
                done_o = 1; cyc_o = c; dr_o = drdata; er_o = derr;
            end
            if (mvalid) begin
                if (nv_o == 0) fv_o = c;
                if (nv_o < 12) a_o[nv_o] = mwdata;
                else if (nv_o < 20) d_o[nv_o-12] = mwdata;
                mm_o = mm_o | mmode;
                nv_o++;
            end else if (nv_o == 12 && !done_o) begin
                p++;
                if (mmode) gap_o++;
                if (!mbreq && sdrop_o == 0) sdrop_o = p;
            end
            if (mbreq) gcnt++; else gcnt = 0;
            mbgrant = (gdly >= 0) && mbreq && (gcnt >= gdly);
            ssplit = split && nv_o == 12 && !mmode && p == 2 && !done_o;
            svalid = 1'b0;
            mrdata = 1'b0;
            if (nv_o == 12 && !mmode && p >= start && b < 8 && !done_o) begin
                if (!alt || ((p - start) % 2 == 0)) begin
                    svalid = 1'b1; mrdata = rv[b]; b++;
                end else begin
                    mrdata = ~rv[b];
                end
            end
        end
        mbgrant = 1'b0; svalid = 1'b0; ssplit = 1'b0; mrdata = 1'b0;
        if (done_o && mm_o && nv_o == 20) mem[a_o] = d_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({drdata, ddone, derr, dbusy, mbreq, mwdata, mmode, mvalid} !== 15'h0) begin
            errs++;
            $display("FAIL reset_outs: got %h want 0",
                     {drdata, ddone, derr, dbusy, mbreq, mwdata, mmode, mvalid});
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({dbusy, mbreq, mvalid, ddone} !== 4'h0) begin
            errs++;
            $display("FAIL idle_outs: got %b want 0000", {dbusy, mbreq, mvalid, ddone});
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        dmode = 1'b1; daddr = 12'h5A3; dwdata = 8'hC6; dreq = 1'b1;
        drive_bus(3, 8'h00, 0, 0, 3, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL wr_done: got %b want 1", done); end
        vecs++; if (oa !== 12'h5A3) begin errs++; $display("FAIL wr_addr: got %h want 5a3", oa); end
        vecs++; if (od !== 8'hC6) begin errs++; $display("FAIL wr_data: got %h want c6", od); end
        vecs++; if (nv !== 20) begin errs++; $display("FAIL wr_nvalid: got %0d want 20", nv); end
        vecs++; if (ngap !== 1) begin errs++; $display("FAIL wr_gap: got %0d want 1", ngap); end
        vecs++; if (fv !== 5) begin errs++; $display("FAIL wr_first_valid: got %0d want 5", fv); end
        vecs++; if (ncyc !== 26) begin errs++; $display("FAIL wr_latency: got %0d want 26", ncyc); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL wr_derr: got %b want 0", er); end
        vecs++; if (mm !== 1'b1) begin errs++; $display("FAIL wr_mmode: got %b want 1", mm); end
        vecs++; if (mem[12'h5A3] !== 8'hC6) begin
            errs++; $display("FAIL wr_mem: got %h want c6", mem[12'h5A3]);
        end
    endtask

    task automatic test_read_alt();
        @(negedge clk);
        dmode = 1'b0; daddr = 12'h010; dreq = 1'b1;
        drive_bus(1, 8'h9D, 1, 0, 3, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL rd_done: got %b want 1", done); end
        vecs++; if (oa !== 12'h010) begin errs++; $display("FAIL rd_addr: got %h want 010", oa); end
        vecs++; if (dr !== 8'h9D) begin errs++; $display("FAIL rd_data: got %h want 9d", dr); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL rd_derr: got %b want 0", er); end
        vecs++; if (mm !== 1'b0) begin errs++; $display("FAIL rd_mmode: got %b want 0", mm); end
    endtask

    task automatic test_split();
        @(negedge clk);
        dmode = 1'b0; daddr = 12'h2B4; dreq = 1'b1;
        drive_bus(0, 8'h3F, 0, 1, 8, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (sdrop !== 3) begin errs++; $display("FAIL split_mbreq_drop: got %0d want 3", sdrop); end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL split_done: got %b want 1", done); end
        vecs++; if (dr !== 8'h3F) begin errs++; $display("FAIL split_data: got %h want 3f", dr); end
        vecs++; if (er !== 1'b0) begin errs++; $display("FAIL split_derr: got %b want 0", er); end
    endtask

    task automatic test_split_vs_valid();
        @(negedge clk);
        dmode = 1'b0; daddr = 12'h7FF; dreq = 1'b1;
        drive_bus(0, 8'hA5, 1, 1, 2, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (sdrop !== 0) begin errs++; $display("FAIL both_mbreq_drop: got %0d want 0", sdrop); end
        vecs++; if (dr !== 8'hA5) begin errs++; $display("FAIL both_data: got %h want a5", dr); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        dmode = 1'b1; daddr = 12'h0F0; dwdata = 8'h77; dreq = 1'b1;
        drive_bus(-1, 8'h00, 0, 0, 3, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (ncyc !== 256) begin errs++; $display("FAIL to_latency: got %0d want 256", ncyc); end
        vecs++; if (er !== 1'b1) begin errs++; $display("FAIL to_derr: got %b want 1", er); end
        vecs++; if (nv !== 0) begin errs++; $display("FAIL to_mvalid: got %0d want 0", nv); end
        vecs++; if (mbreq !== 1'b0) begin errs++; $display("FAIL to_mbreq: got %b want 0", mbreq); end
        vecs++; if (dr !== 8'hA5) begin errs++; $display("FAIL to_drdata_kept: got %h want a5", dr); end
        @(negedge clk);
        vecs++; if ({dbusy, ddone, derr} !== 3'b000) begin
            errs++; $display("FAIL to_idle: got %b want 000", {dbusy, ddone, derr});
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  hit;
        @(negedge clk);
        dmode = 1'b1; daddr = 12'h3C5; dwdata = 8'h5A; dreq = 1'b1; mbgrant = 1'b1;
        n = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            dreq = 1'b0;
            if (mvalid) n++;
            if (n == 17) hit = 1;
        end
        vecs++; if (!hit) begin errs++; $display("FAIL rstmid_reach: got %0d want 17", n); end
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({drdata, ddone, derr, dbusy, mbreq, mwdata, mmode, mvalid} !== 15'h0) begin
            errs++;
            $display("FAIL rstmid_async: got %h want 0",
                     {drdata, ddone, derr, dbusy, mbreq, mwdata, mmode, mvalid});
        end
        @(negedge clk);
        rst = 1'b0; mbgrant = 1'b0;
        dmode = 1'b1; daddr = 12'h001; dwdata = 8'h11; dreq = 1'b1;
        drive_bus(0, 8'h00, 0, 0, 3, 0, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if (oa !== 12'h001) begin errs++; $display("FAIL rstmid_addr: got %h want 001", oa); end
        vecs++; if (od !== 8'h11) begin errs++; $display("FAIL rstmid_data: got %h want 11", od); end
        vecs++; if ({done, er} !== 2'b10) begin
            errs++; $display("FAIL rstmid_done: got %b want 10", {done, er});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dmode = 1'b1; daddr = 12'h123; dwdata = 8'h4E; dreq = 1'b1;
        @(negedge clk);
        daddr = 12'h456; dwdata = 8'hB1;
        drive_bus(2, 8'h00, 0, 0, 3, 1, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        vecs++; if ({oa, od} !== 20'h1234E) begin
            errs++; $display("FAIL b2b_first: got %h want 1234e", {oa, od});
        end
        @(negedge clk);
        vecs++; if ({dbusy, mbreq} !== 2'b00) begin
            errs++; $display("FAIL b2b_idle_gap: got %b want 00", {dbusy, mbreq});
        end
        drive_bus(2, 8'h00, 0, 0, 3, 1, oa, od, nv, ngap, fv, ncyc, done, dr, er, sdrop, mm);
        dreq = 1'b0;
        vecs++; if ({oa, od} !== 20'h456B1) begin
            errs++; $display("FAIL b2b_second: got %h want 456b1", {oa, od});
        end
        vecs++; if (fv !== 4) begin errs++; $display("FAIL b2b_first_valid: got %0d want 4", fv); end
        @(negedge clk);
        @(negedge clk);
        vecs++; if (dbusy !== 1'b0) begin errs++; $display("FAIL b2b_end_idle: got %b want 0", dbusy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_alt();
        test_split();
        test_split_vs_valid();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
